// File: rtl/sag_seq.sv
// sag_seq: time-shares one 8-bit pext extractor to run PEXT (one pass) and
// sheep-and-goats (two passes: ~ci bits low, ci bits packed directly above).
module pext (
   input  logic [7:0] di,
   input  logic [7:0] ci,
   output logic [7:0] po
);
   logic [3:0] j;
   always_comb begin
      po = '0;
      j = '0;
      for (int i = 0; i < 8; i++)
         if (ci[i]) begin
            po[j[2:0]] = di[i];
            j = j + 4'd1;
         end
   end
endmodule

module sag_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_op,
   input  logic [7:0] in_di,
   input  logic [7:0] in_ci,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [3:0] out_cnt,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, PASS0, PASS1, DONE} state_t;
   state_t state, state_n;
   logic       op_r;
   logic [7:0] di_r, ci_r, lo_r, hi_r, mask, px;
   logic [3:0] k;

   function automatic logic [3:0] popcnt(input logic [7:0] v);
      popcnt = '0;
      for (int i = 0; i < 8; i++) popcnt = popcnt + {3'd0, v[i]};
   endfunction

   assign in_ready  = state == IDLE && !rst;
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;
   assign k         = popcnt(~ci_r);
   assign out_cnt   = popcnt(ci_r);
   assign mask      = (state == PASS0 && op_r) ? ~ci_r : ci_r;
   // hi_r is zero when k=8, so bits shifted past bit 7 never matter
   assign out_data  = op_r ? lo_r | (hi_r << k) : lo_r;

   pext u_pext (.di(di_r), .ci(mask), .po(px));

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = (in_valid && in_ready) ? PASS0 : IDLE;
         PASS0:   state_n = op_r ? PASS1 : DONE;
         PASS1:   state_n = DONE;
         DONE:    state_n = out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_r  <= 1'b0;
         di_r  <= '0;
         ci_r  <= '0;
         lo_r  <= '0;
         hi_r  <= '0;
      end else begin
         state <= state_n;
         if (in_valid && in_ready) begin
            op_r <= in_op;
            di_r <= in_di;
            ci_r <= in_ci;
         end
         if (state == PASS0) lo_r <= px;
         if (state == PASS1) hi_r <= px;
      end
   end
endmodule

// File: tb/tb_sag_seq.sv
// tb_sag_seq: vector table, backpressure/reset sequences and a random stream
// checked against a bit-list model of PEXT and sheep-and-goats.
module tb_sag_seq;
   logic       clk = 0, rst = 1;
   logic       in_valid = 0, in_ready, in_op = 0, out_valid, out_ready = 0, busy;
   logic [7:0] in_di = 0, in_ci = 0, out_data;
   logic [3:0] out_cnt;
   int checks = 0, failures = 0;

   sag_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
                .in_op(in_op), .in_di(in_di), .in_ci(in_ci), .out_valid(out_valid),
                .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      logic       op;
      logic [7:0] di, ci, data;
      logic [3:0] cnt;
      int         lat;
      string      nm;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [3:0] cnt;
   } exp_t;

   vec_t tbl[6];
   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
      end
   endtask

   // Ordered list of extracted bits: for SAG the ~ci bits first, then the ci bits.
   function automatic logic [7:0] model(input logic op, input logic [7:0] di, input logic [7:0] ci);
      logic q[$];
      logic [7:0] r = '0;
      if (op) for (int i = 0; i < 8; i++) if (!ci[i]) q.push_back(di[i]);
      for (int i = 0; i < 8; i++) if (ci[i]) q.push_back(di[i]);
      foreach (q[j]) r[j] = q[j];
      return r;
   endfunction

   task automatic run_req(input vec_t v);
      int lat;
      @(negedge clk);
      in_valid = 1; in_op = v.op; in_di = v.di; in_ci = v.ci; out_ready = 0;
      #1 chk({v.nm, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({v.nm, "_latency"}, lat, v.lat);
      chk({v.nm, "_data"}, out_data, v.data);
      chk({v.nm, "_cnt"}, out_cnt, v.cnt);
      out_ready = 1;
      @(negedge clk);
      #1;
      chk({v.nm, "_valid_fall"}, out_valid, 0);
      chk({v.nm, "_idle"}, busy, 0);
      out_ready = 0;
   endtask

   initial begin
      int acc, done, cyc, lat;
      logic seen;
      exp_t e;
      tbl[0] = '{0, 8'hB5, 8'hAA, 8'h0C, 4, 2, "pext_b5_aa"};
      tbl[1] = '{1, 8'hB5, 8'hAA, 8'hC7, 4, 3, "sag_b5_aa"};
      tbl[2] = '{1, 8'hB5, 8'h00, 8'hB5, 0, 3, "sag_ci00"};
      tbl[3] = '{1, 8'hB5, 8'hFF, 8'hB5, 8, 3, "sag_ciff"};
      tbl[4] = '{0, 8'hB5, 8'h00, 8'h00, 0, 2, "pext_ci00"};
      tbl[5] = '{0, 8'h5A, 8'hF0, 8'h05, 4, 2, "pext_hi"};

      // request presented during reset must be ignored
      in_valid = 1; in_op = 1; in_di = 8'hFF; in_ci = 8'h0F;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      rst = 0; in_valid = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_cnt", out_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready_after", in_ready, 1);

      foreach (tbl[i]) run_req(tbl[i]);

      // backpressure with a competing request held on the input
      @(negedge clk);
      in_valid = 1; in_op = 1; in_di = 8'h3C; in_ci = 8'h0F;
      @(negedge clk);
      in_op = 0; in_di = 8'h11; in_ci = 8'hFF;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", lat, 3);
      for (int c = 0; c < 5; c++) begin
         chk("bp_data", out_data, 8'hC3);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_busy", busy, 1);
         chk("bp_valid", out_valid, 1);
         @(negedge clk);
      end
      out_ready = 1;
      @(negedge clk);
      #1;
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_ready", in_ready, 1);
      chk("bp_idle_valid", out_valid, 0);
      @(negedge clk);
      in_valid = 0;
      chk("bp_second_accept", busy, 1);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_second_latency", lat, 2);
      chk("bp_second_data", out_data, 8'h11);
      chk("bp_second_cnt", out_cnt, 8);
      @(negedge clk);
      out_ready = 0;

      // reset while in PASS1
      in_valid = 1; in_op = 1; in_di = 8'hB5; in_ci = 8'hAA;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      chk("mid_busy_pass1", busy, 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      chk("mid_valid", out_valid, 0);
      chk("mid_data", out_data, 0);
      chk("mid_busy", busy, 0);
      chk("mid_in_ready", in_ready, 1);
      out_ready = 1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         seen |= out_valid | busy;
      end
      chk("mid_no_stale", seen, 0);

      // random stream
      acc = 0; done = 0; cyc = 0;
      while ((acc < 1000 || exp_q.size() > 0) && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         in_valid  = acc < 1000 ? 1'($urandom_range(0, 1)) : 1'b0;
         in_op     = 1'($urandom_range(0, 1));
         in_di     = 8'($urandom);
         in_ci     = 8'($urandom);
         out_ready = acc < 1000 ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back('{model(in_op, in_di, in_ci), 4'($countones(in_ci))});
            acc++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("stream_spurious", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("stream_data", out_data, e.data);
               chk("stream_cnt", out_cnt, e.cnt);
               done++;
            end
         end
      end
      chk("stream_drained", exp_q.size(), 0);
      chk("stream_completed", done, 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
